// File: rtl/systolic_result_writer.sv
// Write-back engine for the systolic array result tile: snapshots Out on start and
// streams one masked row per memory beat to base_C + r*dim_col_C.
module systolic_result_writer #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int DW   = 32,
  parameter int AW   = 32,
  parameter int DIMW = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic [ROWS-1:0][COLS-1:0][DW-1:0] Out,
  input  logic [AW-1:0]                     base_C,
  input  logic [DIMW-1:0]                   dim_col_C,
  input  logic [3:0]                        valid_rows,
  input  logic [3:0]                        valid_cols,
  output logic                              write,
  input  logic                              write_ready,
  output logic [AW-1:0]                     write_addr,
  output logic [COLS-1:0][DW-1:0]           writedata,
  output logic [COLS-1:0]                   write_mask,
  output logic                              busy,
  output logic                              done
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t                            state;
  logic [ROWS-1:0][COLS-1:0][DW-1:0] tile;
  logic [AW-1:0]                     stride;
  logic [RW-1:0]                     row;
  logic [RW-1:0]                     last_row;

  logic [3:0]      rows_clamped;
  logic [3:0]      cols_clamped;
  logic [COLS-1:0] lane_mask;

  assign rows_clamped = (valid_rows > 4'(ROWS)) ? 4'(ROWS) : valid_rows;
  assign cols_clamped = (valid_cols > 4'(COLS)) ? 4'(COLS) : valid_cols;

  // Lane enable for the requested column count.
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < COLS; i++) begin
      lane_mask[i] = (32'(i) < 32'(cols_clamped));
    end
  end

  // Masked lanes are forced to zero so stale tile data never leaves the block.
  function automatic logic [COLS-1:0][DW-1:0] masked_row(
    input logic [COLS-1:0][DW-1:0] data,
    input logic [COLS-1:0]         mask
  );
    logic [COLS-1:0][DW-1:0] res;
    for (int i = 0; i < COLS; i++) begin
      res[i] = mask[i] ? data[i] : {DW{1'b0}};
    end
    return res;
  endfunction

  // Control FSM with registered memory-port outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      write      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      write_mask <= '0;
      write_addr <= '0;
      writedata  <= '0;
      row        <= '0;
      last_row   <= '0;
      stride     <= '0;
      tile       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            tile       <= Out;
            stride     <= AW'(dim_col_C);
            row        <= '0;
            last_row   <= RW'(rows_clamped - 4'd1);
            write_addr <= base_C;
            write_mask <= lane_mask;
            busy       <= 1'b1;
            if ((rows_clamped == 4'd0) || (cols_clamped == 4'd0)) begin
              state     <= FIN;
              done      <= 1'b1;
              write     <= 1'b0;
              writedata <= '0;
            end else begin
              state     <= WRITE;
              write     <= 1'b1;
              writedata <= masked_row(Out[0], lane_mask);
            end
          end else begin
            busy  <= 1'b0;
            write <= 1'b0;
          end
        end
        WRITE: begin
          // Outputs are held untouched while the memory stalls.
          if (write_ready) begin
            if (row == last_row) begin
              state      <= FIN;
              write      <= 1'b0;
              done       <= 1'b1;
              write_mask <= '0;
              writedata  <= '0;
            end else begin
              row        <= row + RW'(1'b1);
              write_addr <= write_addr + stride;
              writedata  <= masked_row(tile[row + RW'(1'b1)], write_mask);
            end
          end else begin
            state <= WRITE;
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          write <= 1'b0;
        end
        default: begin
          state <= IDLE;
          write <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_result_writer.sv
// Self-checking bench for systolic_result_writer: directed and random transfers
// compared against a queue of expected beats built from the tile-write rules.
module tb_systolic_result_writer;

  logic                    clock = 1'b0;
  logic                    reset = 1'b1;
  logic                    start = 1'b0;
  logic                    write_ready = 1'b1;
  logic [7:0][7:0][31:0]   out_t = '0;
  logic [31:0]             base_C = 32'd0;
  logic [15:0]             dim_col_C = 16'd0;
  logic [3:0]              valid_rows = 4'd0;
  logic [3:0]              valid_cols = 4'd0;
  logic                    write;
  logic [31:0]             write_addr;
  logic [7:0][31:0]        writedata;
  logic [7:0]              write_mask;
  logic                    busy;
  logic                    done;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0]  addr;
    logic [255:0] data;
    logic [7:0]   mask;
  } beat_t;

  beat_t exp_q[$];

  systolic_result_writer dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .Out         (out_t),
    .base_C      (base_C),
    .dim_col_C   (dim_col_C),
    .valid_rows  (valid_rows),
    .valid_cols  (valid_cols),
    .write       (write),
    .write_ready (write_ready),
    .write_addr  (write_addr),
    .writedata   (writedata),
    .write_mask  (write_mask),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // IEEE-754 single encoding of a small non-negative integer.
  function automatic logic [31:0] f32(input int n);
    int e;
    logic [31:0] m;
    if (n == 0) return 32'h0;
    e = 0;
    for (int b = 0; b < 31; b++) if (n[b]) e = b;
    m = 32'(n) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  task automatic fill_random();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        out_t[r][c] = $urandom;
  endtask

  // Called at a negedge; runs one transfer and checks every beat and the done timing.
  task automatic run(input int r_in, input int c_in, input logic [31:0] base,
                     input logic [15:0] stride, input int mode, input int poke_k,
                     input bit poke_done, input bit scramble);
    int nr, nc, k, acc, done_k;
    logic [7:0][7:0][31:0] snap;
    beat_t b;
    nr = (r_in > 8) ? 8 : r_in;
    nc = (c_in > 8) ? 8 : c_in;
    if (nc == 0) nr = 0;
    snap = out_t;
    exp_q.delete();
    for (int r = 0; r < nr; r++) begin
      b.addr = base + 32'(r) * 32'(stride);
      b.mask = 8'((1 << nc) - 1);
      b.data = '0;
      for (int c = 0; c < nc; c++) b.data[c*32 +: 32] = snap[r][c];
      exp_q.push_back(b);
    end
    valid_rows  = 4'(r_in);
    valid_cols  = 4'(c_in);
    base_C      = base;
    dim_col_C   = stride;
    write_ready = 1'b1;
    start       = 1'b1;
    @(negedge clock);
    start = 1'b0;
    if (scramble) fill_random();
    acc = 0;
    done_k = 0;
    for (k = 1; k <= 200; k++) begin
      start = (k == poke_k);
      if (start) begin
        base_C = $urandom;
        valid_rows = 4'd1;
        valid_cols = 4'd1;
      end
      if (mode == 0) write_ready = 1'b1;
      else if (mode == 1) write_ready = ((k % 3) == 1);
      else write_ready = 1'($urandom % 2);
      if (write) begin
        if (exp_q.size() == 0) begin
          chk("beat_count", 256'(acc + 1), 256'(nr));
        end else begin
          chk("addr", write_addr, exp_q[0].addr);
          chk("mask", write_mask, exp_q[0].mask);
          chk("data", writedata, exp_q[0].data);
          if (write_ready) begin
            void'(exp_q.pop_front());
            acc++;
          end
        end
      end
      if (done) begin
        done_k = k;
        break;
      end
      chk("busy_run", busy, 1'b1);
      @(negedge clock);
    end
    start = 1'b0;
    chk("done_seen", done_k != 0, 1'b1);
    chk("accepted", 256'(acc), 256'(nr));
    chk("write_at_done", write, 1'b0);
    chk("busy_at_done", busy, 1'b1);
    if (mode == 0) chk("done_cycle", 256'(done_k), 256'(nr + 1));
    start = poke_done;
    @(negedge clock);
    start = 1'b0;
    write_ready = 1'b1;
    chk("done_pulse", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_write", write, 1'b0);
  endtask

  initial begin
    int nw;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_write", write, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_mask", write_mask, 8'h00);
    chk("rst_addr", write_addr, 32'h0);
    chk("rst_data", writedata, 256'h0);
    reset = 1'b0;
    @(negedge clock);

    // Full tile with float-encoded indices.
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        out_t[r][c] = f32(r * 8 + c);
    run(8, 8, 32'd140, 16'd8, 0, 0, 1'b0, 1'b1);

    // Strided edge tile.
    fill_random();
    run(3, 5, 32'd1000, 16'd20, 0, 0, 1'b0, 1'b1);

    // Backpressure 1,0,0,1,...
    fill_random();
    run(8, 8, 32'd140, 16'd8, 1, 0, 1'b0, 1'b1);

    // Degenerate and clamped sizes.
    run(0, 8, 32'd500, 16'd8, 0, 0, 1'b0, 1'b0);
    run(8, 0, 32'd500, 16'd8, 0, 0, 1'b0, 1'b0);
    fill_random();
    run(12, 8, 32'd64, 16'd9, 0, 0, 1'b0, 1'b0);
    run(2, 15, 32'd7, 16'd3, 0, 0, 1'b0, 1'b0);

    // Zero stride and address wrap.
    fill_random();
    run(3, 8, 32'd300, 16'd0, 0, 0, 1'b0, 1'b0);
    run(8, 6, 32'hFFFF_FFF0, 16'hFFFF, 0, 0, 1'b0, 1'b1);

    // Start during WRITE and on the done cycle is ignored; then a fresh start.
    fill_random();
    run(8, 8, 32'd2000, 16'd8, 0, 2, 1'b1, 1'b0);
    fill_random();
    run(4, 7, 32'd3000, 16'd11, 0, 0, 1'b0, 1'b1);

    // Reset after three accepted beats.
    fill_random();
    base_C = 32'd140;
    dim_col_C = 16'd8;
    valid_rows = 4'd8;
    valid_cols = 4'd8;
    write_ready = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    chk("pre_rst_write", write, 1'b1);
    chk("pre_rst_addr", write_addr, 32'd164);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_rst_write", write, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    nw = 0;
    repeat (10) begin
      @(negedge clock);
      if (write || busy) nw++;
    end
    chk("rst_no_beats", 256'(nw), 256'(0));
    fill_random();
    run(8, 8, 32'd140, 16'd8, 0, 0, 1'b0, 1'b0);

    // Random transfers with random backpressure.
    for (int i = 0; i < 8; i++) begin
      fill_random();
      run(int'($urandom_range(0, 12)), int'($urandom_range(0, 12)), $urandom,
          16'($urandom), 2, 0, 1'b0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_result_writer.md
Name: systolic_result_writer

Overview:
- Write-back engine for the 8x8 systolic array.
- On start, it snapshots the array's result tile (the Out matrix) and writes it to memory one row per beat, as BANDWIDTH-word writes at base_C + r*dim_col_C.
- It is the write-direction counterpart of the driver's readA/readB read path and shares the same word-addressed memory port conventions.
- It supports partial edge tiles through valid_rows/valid_cols, and per-lane write masking.

Parameters:
- ROWS, 8, tile rows; equals the systolic array height.
- COLS, `BANDWIDTH (8), tile columns; one row per memory beat.
- DW, `DATA_WIDTH (32), element width (IEEE-754 single bits, passed through untouched).
- AW, `ADDR_WIDTH, word address width.
- DIMW, `DIM_WIDTH, stride/dimension width.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- Out  in  [ROWS-1:0][COLS-1:0][DW-1:0]  result tile from SystolicArray_Driver.
- base_C  in  AW  word address of tile element [0][0].
- dim_col_C  in  DIMW  row stride in words (destination matrix column count).
- valid_rows  in  4  rows to write, 0..8.
- valid_cols  in  4  columns to write, 0..8.
- write  out  1  write request, valid this cycle.
- write_ready  in  1  memory accepts the current beat when write && write_ready.
- write_addr  out  AW  word address of lane 0.
- writedata  out  [COLS-1:0][DW-1:0]  row data; lane i -> write_addr+i.
- write_mask  out  COLS  lane enables.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset, synchronous and applied at any state (including mid-burst):
  - State goes to IDLE.
  - write, busy, done, write_mask, write_addr, writedata and row counter all go to 0.
  - The in-flight transfer is abandoned; no further beats are issued.
- States: IDLE, WRITE, FIN.
- IDLE:
  - On start, latch Out, base_C, dim_col_C, valid_rows and valid_cols into internal registers.
  - valid_rows and valid_cols above 8 are clamped to 8.
  - Set row=0 and addr=base_C.
  - If the clamped valid_rows is 0 or the clamped valid_cols is 0, go to FIN; otherwise go to WRITE.
  - Inputs are not referenced after the start cycle; Out may change freely.
- WRITE:
  - write=1, write_addr=addr, writedata=latched row[row], write_mask[i]=(i<valid_cols).
  - Masked lanes drive writedata=0.
  - First write occurs the cycle after start.
  - All outputs stay stable while write && !write_ready.
  - On acceptance (write && write_ready):
    - If row == valid_rows-1, go to FIN with write=0 next cycle.
    - Otherwise row+1 and addr += dim_col_C, with the stride zero-extended to AW.
  - Address arithmetic is modulo 2^AW; wrap-around is not flagged.
  - No multiplier: the address is updated by accumulation.
- FIN: done=1 for exactly one cycle, busy=1, then go to IDLE.
- busy = (state != IDLE).
- start while busy is ignored; it is not queued.
- start in the same cycle as done: ignored. It must be reasserted once IDLE is reached.
- Throughput with write_ready held high: one row per cycle.
- Latency with write_ready held high:
  - start at cycle t gives beats at t+1..t+R, and done at t+R+1.
  - R=0 gives done at t+1.
- Row order is strictly 0 upward; each row is written exactly once.
- dim_col_C=0 is legal: every row goes to base_C, last row wins.

Test Plan:
- Full tile: base_C=140, dim_col_C=8, rows/cols=8/8, write_ready tied 1, Out[r][c]=$shortrealtobits(r*8+c). Required: 8 beats at addresses 140,148,...,196 on consecutive cycles; mask=8'hFF; writedata matches; done exactly 1 cycle after the last beat.
- Strided edge tile: base_C=1000, dim_col_C=20, rows=3, cols=5. Required: beats at 1000, 1020, 1040; mask=8'h1F; lanes 5..7 are zero; done at start+4.
- Backpressure: write_ready toggles 1,0,0,1,... Required: write_addr, writedata and mask stay stable while stalled; no row is skipped or repeated; total accepted beats = 8.
- Degenerate: valid_rows=0 (then valid_cols=0; then valid_rows=12 clamped to 8). Required: 0 writes with done at start+1 in the zero cases; 8 writes in the clamped case.
- Re-entry/ignore: start pulsed during WRITE and on the done cycle. Required: neither starts a new transfer. A start one cycle after returning to IDLE runs a fresh transfer using Out as sampled at that new start.
- Reset mid-operation: reset asserted after 3 beats. Required:
  - The next cycle shows write=0, busy=0, done=0.
  - No further beats occur.
  - A subsequent start writes from row 0 again.
